ex_issue: RTL and testbench

ID/EX pipeline stage that drives the 64-bit execute ALU. Accepts decoded instructions from ID over a valid/ready handshake and registers them. Translates funct3/funct7 into the ALU's `alu_op` / `sub_as_carry` encoding, resolves operands through MEM/WB forwarding, and presents `alu_a`, `alu_b`, `alu_op` and `alu_sub_as_carry` to the ALU for one EX cycle per instruction.

---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/ex_fwd_mux.sv | 30 +++
 rtl/ex_issue.sv | 144 ++++++++++++++
 tb/tb_ex_issue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, ALU op encodings and the funct3 decoder for the EX issue stage.
package alu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ShamtW = 6;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSl  = 3'd1,
    AluSr  = 3'd2,
    AluXor = 3'd3,
    AluOr  = 3'd4,
    AluAnd = 3'd5,
    AluNop = 3'd7
  } alu_op_e;

  localparam logic [2:0] F3Add = 3'b000;
  localparam logic [2:0] F3Sl  = 3'b001;
  localparam logic [2:0] F3Xor = 3'b100;
  localparam logic [2:0] F3Sr  = 3'b101;
  localparam logic [2:0] F3Or  = 3'b110;
  localparam logic [2:0] F3And = 3'b111;

  typedef struct packed {
    alu_op_e op;
    logic    sub;
    logic    shift;
    logic    illegal;
  } dec_t;

  // Map funct3/funct7b5 onto the ALU encoding; SUB and SRA are special-cased.
  function automatic dec_t decode(input logic [2:0] funct3, input logic funct7b5,
                                  input logic use_imm);
    dec_t d;
    d = '{op: AluNop, sub: 1'b0, shift: 1'b0, illegal: 1'b0};
    unique case (funct3)
      F3Add: begin
        d.op  = AluAdd;
        d.sub = !use_imm && funct7b5;
      end
      F3Sl: begin
        d.op    = AluSl;
        d.shift = 1'b1;
      end
      F3Xor: d.op = AluXor;
      F3Sr: begin
        if (funct7b5) begin
          d.illegal = 1'b1;  // SRA has no ALU encoding
        end else begin
          d.op    = AluSr;
          d.shift = 1'b1;
        end
      end
      F3Or:  d.op = AluOr;
      F3And: d.op = AluAnd;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ex_fwd_mux.sv
// One operand's forwarding select: MEM result beats WB result, x0 never forwards.
module ex_fwd_mux
  import alu_pkg::*;
#(
  parameter bit FwdEn = 1'b1
) (
  input  logic [4:0]      idx,
  input  logic [XLEN-1:0] reg_val,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] val
);

  // Priority select with the registered value as fallback.
  always_comb begin
    val = reg_val;
    if (FwdEn && idx != 5'd0) begin
      if (mem_valid && mem_rd == idx) begin
        val = mem_data;
      end else if (wb_valid && wb_rd == idx) begin
        val = wb_data;
      end
    end
  end

endmodule

// File: rtl/ex_issue.sv
// ID/EX issue stage feeding the 64-bit ALU.
// Define EX_FWD_EN to build MEM/WB operand forwarding and the stall-time operand refresh;
// without it the forwarding ports are ignored and operands come from the captured values.
module ex_issue
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_use_imm,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            mem_fwd_valid,
  input  logic            wb_fwd_valid,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  output logic [4:0]      ex_rd,
  output logic            ex_illegal,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_sub_as_carry
);

`ifdef EX_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic            valid_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0] rs1_val_q, rs2_val_q, imm_q;
  logic            use_imm_q;
  dec_t            dec_q;

  logic            capture, stall;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, b_src;

  assign id_ready = !rst && (!valid_q || ex_ready);
  assign capture  = id_valid && id_ready;
  assign stall    = valid_q && !ex_ready;
  assign ex_valid = valid_q;
  assign ex_rd    = rd_q;

  ex_fwd_mux #(.FwdEn(FwdEn)) u_fwd_a (
    .idx       (rs1_q),
    .reg_val   (rs1_val_q),
    .mem_valid (mem_fwd_valid),
    .mem_rd    (mem_fwd_rd),
    .mem_data  (mem_fwd_data),
    .wb_valid  (wb_fwd_valid),
    .wb_rd     (wb_fwd_rd),
    .wb_data   (wb_fwd_data),
    .val       (rs1_fwd)
  );

  ex_fwd_mux #(.FwdEn(FwdEn)) u_fwd_b (
    .idx       (rs2_q),
    .reg_val   (rs2_val_q),
    .mem_valid (mem_fwd_valid),
    .mem_rd    (mem_fwd_rd),
    .mem_data  (mem_fwd_data),
    .wb_valid  (wb_fwd_valid),
    .wb_rd     (wb_fwd_rd),
    .wb_data   (wb_fwd_data),
    .val       (rs2_fwd)
  );

  // EX slot register: capture, hold/refresh on stall, drop on flush or consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      dec_q     <= '{op: AluNop, sub: 1'b0, shift: 1'b0, illegal: 1'b0};
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q <= 1'b1;
      end else if (ex_ready) begin
        valid_q <= 1'b0;
      end

      if (capture && !flush) begin
        rs1_q     <= id_rs1;
        rs2_q     <= id_rs2;
        rd_q      <= id_rd;
        rs1_val_q <= id_rs1_val;
        rs2_val_q <= id_rs2_val;
        imm_q     <= id_imm;
        use_imm_q <= id_use_imm;
        dec_q     <= decode(id_funct3, id_funct7b5, id_use_imm);
      end else if (FwdEn && stall) begin
        // Latch forwarded values so a producer retiring mid-stall is not lost.
        rs1_val_q <= rs1_fwd;
        rs2_val_q <= rs2_fwd;
      end
    end
  end

  assign b_src = use_imm_q ? imm_q : rs2_fwd;

  // ALU port drive; an empty slot presents a zeroed NOP.
  always_comb begin
    alu_a            = '0;
    alu_b            = '0;
    alu_op           = AluNop;
    alu_sub_as_carry = 1'b0;
    ex_illegal       = 1'b0;
    if (valid_q) begin
      alu_op           = dec_q.op;
      alu_sub_as_carry = dec_q.sub;
      ex_illegal       = dec_q.illegal;
      alu_a            = rs1_fwd;
      if (dec_q.sub) begin
        alu_b = ~rs2_fwd;  // inversion after forwarding; carry-in completes the negate
      end else if (dec_q.shift) begin
        alu_b = {{(XLEN - ShamtW){1'b0}}, b_src[ShamtW-1:0]};
      end else begin
        alu_b = b_src;
      end
    end
  end

endmodule

// File: tb/tb_ex_issue.sv
// Directed bench for ex_issue with an expected-result scoreboard.
module tb_ex_issue;
  import alu_pkg::*;

`ifdef EX_FWD_EN
  localparam bit TbFwd = 1'b1;
`else
  localparam bit TbFwd = 1'b0;
`endif

  logic        clk, rst, id_valid, id_ready, id_funct7b5, id_use_imm, flush, ex_ready;
  logic [63:0] id_rs1_val, id_rs2_val, id_imm, mem_fwd_data, wb_fwd_data, alu_a, alu_b;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_fwd_rd, wb_fwd_rd, ex_rd;
  logic [2:0]  id_funct3, alu_op;
  logic        mem_fwd_valid, wb_fwd_valid, ex_valid, ex_illegal, alu_sub_as_carry;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        ill;
    logic [4:0]  rd;
    bit          chk_ab;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ex_issue dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_rs1_val       (id_rs1_val),
    .id_rs2_val       (id_rs2_val),
    .id_imm           (id_imm),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rd            (id_rd),
    .id_funct3        (id_funct3),
    .id_funct7b5      (id_funct7b5),
    .id_use_imm       (id_use_imm),
    .flush            (flush),
    .ex_ready         (ex_ready),
    .mem_fwd_valid    (mem_fwd_valid),
    .wb_fwd_valid     (wb_fwd_valid),
    .mem_fwd_rd       (mem_fwd_rd),
    .wb_fwd_rd        (wb_fwd_rd),
    .mem_fwd_data     (mem_fwd_data),
    .wb_fwd_data      (wb_fwd_data),
    .ex_valid         (ex_valid),
    .ex_rd            (ex_rd),
    .ex_illegal       (ex_illegal),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_op           (alu_op),
    .alu_sub_as_carry (alu_sub_as_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode: operand values given are the effective (post-forward) ones.
  function automatic exp_t model(input logic [2:0] f3, input logic f7, input logic ui,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] imm, input logic [4:0] rd);
    exp_t e;
    logic [63:0] bs;
    bs = ui ? imm : b;
    e.a = a; e.b = bs; e.sub = 1'b0; e.ill = 1'b0; e.rd = rd; e.chk_ab = 1'b1; e.op = 3'd7;
    case (f3)
      3'b000: begin
        e.op = 3'd0;
        if (!ui && f7) begin e.b = ~b; e.sub = 1'b1; end
      end
      3'b001: begin e.op = 3'd1; e.b = bs & 64'h3f; end
      3'b100: e.op = 3'd3;
      3'b101: begin
        if (f7) begin e.ill = 1'b1; e.chk_ab = 1'b0; end
        else begin e.op = 3'd2; e.b = bs & 64'h3f; end
      end
      3'b110: e.op = 3'd4;
      3'b111: e.op = 3'd5;
      default: begin e.ill = 1'b1; e.chk_ab = 1'b0; end
    endcase
    return e;
  endfunction

  task automatic check_front(input string tag, input bit pop);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb[0];
      chk({tag, "_valid"}, 64'(ex_valid), 64'd1);
      chk({tag, "_op"}, 64'(alu_op), 64'(e.op));
      chk({tag, "_sub"}, 64'(alu_sub_as_carry), 64'(e.sub));
      chk({tag, "_ill"}, 64'(ex_illegal), 64'(e.ill));
      chk({tag, "_rd"}, 64'(ex_rd), 64'(e.rd));
      if (e.chk_ab) begin
        chk({tag, "_a"}, alu_a, e.a);
        chk({tag, "_b"}, alu_b, e.b);
      end
      if (pop) void'(sb.pop_front());
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 64'(ex_valid), 64'd0);
    chk({tag, "_rd"}, 64'(ex_rd), 64'd0);
    chk({tag, "_ill"}, 64'(ex_illegal), 64'd0);
    chk({tag, "_op"}, 64'(alu_op), 64'd7);
    chk({tag, "_a"}, alu_a, 64'd0);
    chk({tag, "_b"}, alu_b, 64'd0);
    chk({tag, "_sub"}, 64'(alu_sub_as_carry), 64'd0);
    chk({tag, "_ready"}, 64'(id_ready), 64'd0);
  endtask

  task automatic drive(input logic [4:0] r1, input logic [63:0] v1, input logic [4:0] r2,
                       input logic [63:0] v2, input logic [63:0] imm, input logic [4:0] rd,
                       input logic [2:0] f3, input logic f7, input logic ui);
    id_rs1 = r1; id_rs1_val = v1; id_rs2 = r2; id_rs2_val = v2; id_imm = imm; id_rd = rd;
    id_funct3 = f3; id_funct7b5 = f7; id_use_imm = ui; id_valid = 1'b1;
  endtask

  // Issue one instruction, push its expectation, and check it one cycle after the handshake.
  task automatic issue(input string tag, input logic [4:0] r1, input logic [63:0] v1,
                       input logic [4:0] r2, input logic [63:0] v2, input logic [63:0] imm,
                       input logic [4:0] rd, input logic [2:0] f3, input logic f7,
                       input logic ui, input logic [63:0] ea, input logic [63:0] eb);
    @(posedge clk); #1;
    drive(r1, v1, r2, v2, imm, rd, f3, f7, ui);
    sb.push_back(model(f3, f7, ui, ea, eb, imm, rd));
    @(posedge clk); #1;
    id_valid = 1'b0;
    @(negedge clk);
    check_front(tag, 1'b1);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rs1_val = '0; id_rs2_val = '0; id_imm = '0;
    id_funct3 = '0; id_funct7b5 = 1'b0; id_use_imm = 1'b0;
    mem_fwd_valid = 1'b0; wb_fwd_valid = 1'b0; mem_fwd_rd = '0; wb_fwd_rd = '0;
    mem_fwd_data = '0; wb_fwd_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(id_ready), 64'd1);

    issue("add", 5'd1, 64'd5, 5'd2, 64'd7, 64'd0, 5'd3, 3'b000, 1'b0, 1'b0, 64'd5, 64'd7);
    issue("sub", 5'd1, 64'd10, 5'd2, 64'd3, 64'd0, 5'd4, 3'b000, 1'b1, 1'b0, 64'd10, 64'd3);
    issue("addi_f7", 5'd1, 64'd10, 5'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd4, 3'b000, 1'b1,
          1'b1, 64'd10, 64'd0);

    // MEM and WB both hold x5; MEM must win.
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 64'h20;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 64'h30;
    issue("fwd_mem", 5'd5, 64'd1, 5'd7, 64'd2, 64'd0, 5'd8, 3'b000, 1'b0, 1'b0,
          TbFwd ? 64'h20 : 64'd1, 64'd2);
    mem_fwd_rd = 5'd0; mem_fwd_data = 64'h55; wb_fwd_rd = 5'd0; wb_fwd_data = 64'h66;
    issue("fwd_x0", 5'd0, 64'd0, 5'd7, 64'd2, 64'd0, 5'd8, 3'b000, 1'b0, 1'b0, 64'd0, 64'd2);
    mem_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;

    // Three stalled cycles; WB offers x6 only during the first one.
    @(posedge clk); #1;
    drive(5'd1, 64'd4, 5'd6, 64'h11, 64'd0, 5'd9, 3'b000, 1'b0, 1'b0);
    sb.push_back(model(3'b000, 1'b0, 1'b0, 64'd4, TbFwd ? 64'h99 : 64'h11, 64'd0, 5'd9));
    @(posedge clk); #1;
    id_valid = 1'b0; ex_ready = 1'b0;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd6; wb_fwd_data = 64'h99;
    @(negedge clk);
    check_front("stall0", 1'b0);
    chk("stall_ready", 64'(id_ready), 64'd0);
    @(posedge clk); #1;
    wb_fwd_valid = 1'b0;
    @(negedge clk);
    check_front("stall1", 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_front("stall2", 1'b0);
    @(posedge clk); #1;
    ex_ready = 1'b1;
    @(negedge clk);
    check_front("stall_release", 1'b1);

    issue("sll", 5'd1, 64'd3, 5'd2, 64'h1_0000_0041, 64'd0, 5'd10, 3'b001, 1'b0, 1'b0,
          64'd3, 64'h1_0000_0041);
    issue("f3_010", 5'd1, 64'd3, 5'd2, 64'd4, 64'd0, 5'd10, 3'b010, 1'b0, 1'b0, 64'd3, 64'd4);
    issue("sra", 5'd1, 64'd3, 5'd2, 64'd4, 64'd0, 5'd11, 3'b101, 1'b1, 1'b0, 64'd3, 64'd4);

    // Back-to-back: XOR then SRLI with no bubble.
    @(posedge clk); #1;
    drive(5'd1, 64'hF0, 5'd2, 64'h0F, 64'd0, 5'd12, 3'b100, 1'b0, 1'b0);
    sb.push_back(model(3'b100, 1'b0, 1'b0, 64'hF0, 64'h0F, 64'd0, 5'd12));
    @(posedge clk); #1;
    drive(5'd1, 64'h100, 5'd2, 64'd0, 64'h45, 5'd13, 3'b101, 1'b0, 1'b1);
    sb.push_back(model(3'b101, 1'b0, 1'b1, 64'h100, 64'd0, 64'h45, 5'd13));
    @(negedge clk);
    check_front("b2b_xor", 1'b1);
    chk("b2b_ready", 64'(id_ready), 64'd1);
    @(posedge clk); #1;
    id_valid = 1'b0;
    @(negedge clk);
    check_front("b2b_srli", 1'b1);

    // Flush in the same cycle as a handshake drops the instruction.
    @(posedge clk); #1;
    drive(5'd1, 64'd1, 5'd2, 64'd2, 64'd0, 5'd14, 3'b000, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 64'(id_ready), 64'd1);
    @(posedge clk); #1;
    id_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_op", 64'(alu_op), 64'd7);

    // Reset while stalled discards the held instruction.
    @(posedge clk); #1;
    drive(5'd1, 64'd8, 5'd2, 64'd9, 64'd0, 5'd15, 3'b110, 1'b0, 1'b0);
    sb.push_back(model(3'b110, 1'b0, 1'b0, 64'd8, 64'd9, 64'd0, 5'd15));
    @(posedge clk); #1;
    id_valid = 1'b0; ex_ready = 1'b0;
    @(negedge clk);
    check_front("pre_rst", 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset("rst_stall");
    @(posedge clk); #1;
    rst = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 64'(id_ready), 64'd1);
    chk("rst_release_valid", 64'(ex_valid), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
